// File: rtl/ser_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per clock, unsigned or
// two's-complement, early exit on the first unequal digit, start/busy/done handshake.
module ser_mag_comp #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             G,
   output logic             L,
   output logic             E
);

   localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((DIGIT == 0) ? 1'b1 : ((WIDTH % DIGIT) != 0 || WIDTH < 2)) begin : g_bad_params
         $error("ser_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
      end
   endgenerate

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic             done_q, done_d;
   logic             g_q, g_d, l_q, l_d, e_q, e_d;

   logic [DIGIT-1:0] da, db;
   logic             gd, ld, eq_run;

   // Bit cells combined with MSB priority: a bit only decides if all higher bits are equal.
   always_comb begin
      da     = a_q[WIDTH-1 -: DIGIT];
      db     = b_q[WIDTH-1 -: DIGIT];
      gd     = 1'b0;
      ld     = 1'b0;
      eq_run = 1'b1;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         gd     = gd | (eq_run & da[i] & ~db[i]);
         ld     = ld | (eq_run & ~da[i] & db[i]);
         eq_run = eq_run & ~(da[i] ^ db[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      done_d  = 1'b0;
      g_d     = g_q;
      l_d     = l_q;
      e_d     = e_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Flipping the sign bit maps two's-complement order onto unsigned order.
               a_d     = A ^ {signed_mode, {(WIDTH-1){1'b0}}};
               b_d     = B ^ {signed_mode, {(WIDTH-1){1'b0}}};
               k_d     = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (clr) begin
               state_d = StIdle;
            end else if (gd || ld) begin
               g_d     = gd;
               l_d     = ld;
               e_d     = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (k_q == KW'(NDIG - 1)) begin
               g_d     = 1'b0;
               l_d     = 1'b0;
               e_d     = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               k_d = k_q + KW'(1);
               a_d = a_q << DIGIT;
               b_d = b_q << DIGIT;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         done_q  <= done_d;
         g_q     <= g_d;
         l_q     <= l_d;
         e_q     <= e_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = done_q;
   assign G    = g_q;
   assign L    = l_q;
   assign E    = e_q;

endmodule

// File: tb/tb_ser_mag_comp.sv
// Directed self-checking bench for ser_mag_comp (WIDTH=16, DIGIT=4).
module tb_ser_mag_comp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, clr, signed_mode;
   logic [15:0] A, B;
   logic        busy, done, G, L, E;

   int tests = 0;
   int fails = 0;

   ser_mag_comp #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .signed_mode(signed_mode),
      .A(A), .B(B), .busy(busy), .done(done), .G(G), .L(L), .E(E)
   );

   always #5 clk = ~clk;

   // Issues one start edge, then counts edges until done (-1 on timeout).
   task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic sm,
                          output int lat);
      @(negedge clk);
      A = a; B = b; signed_mode = sm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; clr = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, G, L, E} !== 5'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected 00000", {busy, done, G, L, E});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_equal;
      int lat;
      run_cmp(16'hBEEF, 16'hBEEF, 1'b0, lat);
      tests++;
      if (lat !== 4) begin
         fails++; $display("FAIL equal_latency: got %0d expected 4", lat);
      end
      tests++;
      if ({G, L, E} !== 3'b001) begin
         fails++; $display("FAIL equal_gle: got %b expected 001", {G, L, E});
      end
   endtask

   task automatic test_top_digit;
      int lat;
      run_cmp(16'h9000, 16'h1FFF, 1'b0, lat);
      tests++;
      if (lat !== 1 || {G, L, E} !== 3'b100) begin
         fails++; $display("FAIL top_unsigned: got lat %0d gle %b expected lat 1 gle 100", lat, {G, L, E});
      end
      run_cmp(16'h9000, 16'h1FFF, 1'b1, lat);
      tests++;
      if (lat !== 1 || {G, L, E} !== 3'b010) begin
         fails++; $display("FAIL top_signed: got lat %0d gle %b expected lat 1 gle 010", lat, {G, L, E});
      end
   endtask

   task automatic test_late;
      int lat;
      run_cmp(16'h1234, 16'h1235, 1'b0, lat);
      tests++;
      if (lat !== 4 || {G, L, E} !== 3'b010) begin
         fails++; $display("FAIL late_last: got lat %0d gle %b expected lat 4 gle 010", lat, {G, L, E});
      end
      run_cmp(16'h1244, 16'h1234, 1'b0, lat);
      tests++;
      if (lat !== 3 || {G, L, E} !== 3'b100) begin
         fails++; $display("FAIL late_third: got lat %0d gle %b expected lat 3 gle 100", lat, {G, L, E});
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      bit extra;
      @(negedge clk);
      A = 16'h1244; B = 16'h1234; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL busy_after_start: got %b expected 1", busy);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            A = 16'h0000; B = 16'hFFFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      tests++;
      if (lat !== 3 || {G, L, E} !== 3'b100) begin
         fails++; $display("FAIL busy_ignore: got lat %0d gle %b expected lat 3 gle 100", lat, {G, L, E});
      end
      extra = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || busy) extra = 1'b1;
      end
      tests++;
      if (extra !== 1'b0) begin
         fails++; $display("FAIL busy_no_queue: got activity %b expected 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      run_cmp(16'h9000, 16'h1FFF, 1'b0, lat);
      // Still in the done cycle: start is driven before the next edge.
      A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL b2b_no_gap: got busy %b expected 1", busy);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      tests++;
      if (lat !== 4 || {G, L, E} !== 3'b001) begin
         fails++; $display("FAIL b2b_second: got lat %0d gle %b expected lat 4 gle 001", lat, {G, L, E});
      end
   endtask

   task automatic test_abort;
      int  lat;
      bit  seen;
      run_cmp(16'h1244, 16'h1234, 1'b0, lat);
      @(negedge clk);
      A = 16'h1234; B = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL abort_idle: got busy %b done %b expected 0 0", busy, done);
      end
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0 || {G, L, E} !== 3'b100) begin
         fails++; $display("FAIL abort_hold: got done_seen %b gle %b expected 0 100", seen, {G, L, E});
      end
      // clr in the cycle that would have completed the compare wins.
      @(negedge clk);
      A = 16'h0000; B = 16'hF000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || {G, L, E} !== 3'b100) begin
         fails++; $display("FAIL abort_priority: got done %b busy %b gle %b expected 0 0 100", done, busy, {G, L, E});
      end
      // clr in IDLE does not block start.
      @(negedge clk);
      A = 16'h0000; B = 16'hF000; start = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      tests++;
      if (lat !== 1 || {G, L, E} !== 3'b010) begin
         fails++; $display("FAIL clr_idle_start: got lat %0d gle %b expected lat 1 gle 010", lat, {G, L, E});
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      @(negedge clk);
      A = 16'h1234; B = 16'h1235; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, G, L, E} !== 5'b0) begin
         fails++; $display("FAIL reset_mid_outputs: got %b expected 00000", {busy, done, G, L, E});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0 || {G, L, E} !== 3'b000) begin
         fails++; $display("FAIL reset_mid_quiet: got activity %b gle %b expected 0 000", seen, {G, L, E});
      end
      run_cmp(16'h8000, 16'h7FFF, 1'b1, lat);
      tests++;
      if (lat !== 1 || {G, L, E} !== 3'b010) begin
         fails++; $display("FAIL reset_mid_restart: got lat %0d gle %b expected lat 1 gle 010", lat, {G, L, E});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_equal();
      test_top_digit();
      test_late();
      test_busy_ignore();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ser_mag_comp.md
Name: ser_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode.
- Stops early at the first unequal digit and reports G/L/E with a start/busy/done handshake.
- Used where wide compares must not sit in a single combinational path, e.g. threshold checks on datapath counters.

Parameters:
- WIDTH, 16, operand width in bits. Must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 4, bits compared per clock. Must be ≥ 1.
- NDIG (localparam), WIDTH/DIGIT, number of digits per compare.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a compare; sampled only in IDLE.
- clr  input  1  synchronous abort of the compare in progress.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results update.
- G  output  1  A > B, held from done until the next done or reset.
- L  output  1  A < B, held from done until the next done or reset.
- E  output  1  A == B, held from done until the next done or reset.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = done = G = L = E = 0; digit index = 0.
  - Reset mid-compare discards the operation; no done is issued.
- FSM states: IDLE and RUN. busy = (state == RUN). done is a registered pulse.
- IDLE:
  - On an edge with start = 1: latch A and B into shift registers.
  - If signed_mode = 1, invert bit WIDTH-1 of both latched copies. This maps two's-complement ordering onto unsigned ordering.
  - Set digit index k = 0 and go to RUN.
  - Outputs G/L/E keep their previous values.
- RUN, digit k (k = 0 is the most-significant digit):
  - Digit-level compare uses the 1-bit G/L/E cells combined in MSB-priority order.
  - gd = g[msb] | e[msb]&g[msb-1] | ...; ld is formed the same way with l; ed = AND of all e.
- RUN, edge update:
  - If gd or ld: G = gd, L = ld, E = 0, done = 1, go to IDLE (early exit).
  - Else if k == NDIG-1: G = 0, L = 0, E = 1, done = 1, go to IDLE.
  - Else: k = k+1, shift both registers left by DIGIT.
- Latency from the start edge to the done-high cycle:
  - Operands first differing in digit k: k+1 cycles.
  - Equal operands: NDIG cycles.
- done is high for exactly one cycle. The FSM is already in IDLE during that cycle, so start there is accepted (back-to-back compares, no bubble).
- start while busy = 1 is ignored; no queueing.
- clr = 1 in RUN: go to IDLE at that edge, no done, G/L/E unchanged. clr has priority over completion in the same cycle.
- clr in IDLE: no effect, and start is still honoured.
- A, B and signed_mode may change freely after the capture edge; only the latched copies are used.
- Invariant: at most one of G/L/E is 1. After reset all three are 0 until the first done.
- Parameter check: if WIDTH % DIGIT != 0, elaboration must fail via a generate-time error.

Test Plan (WIDTH=16, DIGIT=4):
- Reset value and equal operands:
  - Hold rst_n low → busy = done = G = L = E = 0.
  - Release, start with A = B = 16'hBEEF, unsigned → done 4 cycles after the start edge, E = 1, G = L = 0.
- Early exit on the top digit:
  - start A = 16'h9000, B = 16'h1FFF, unsigned → done 1 cycle after start, G = 1.
  - Same operands with signed_mode = 1 → done 1 cycle after start, L = 1 (−28672 < 8191).
- Late difference:
  - A = 16'h1234, B = 16'h1235, unsigned → done 4 cycles after start, L = 1.
  - A = 16'h1244, B = 16'h1234 → done 3 cycles after start, G = 1.
- Handshake:
  - Pulse start again while busy, with A = 0 and B = 16'hFFFF → ignored, the first result is unchanged.
  - start in the done cycle → second compare completes normally with no idle gap.
- Abort:
  - start A = 16'h1234, B = 16'h1234, then assert clr on the 2nd RUN cycle → busy drops, no done pulse, G/L/E keep the prior values.
- Reset mid-operation:
  - Drop rst_n asynchronously (between clock edges) during RUN → busy and all outputs go to 0 immediately, no done after release.
  - A new start afterwards completes correctly.
